// File: rtl/stream_chunk_gate_pkg.sv
// Shared constants and types for stream_chunk_gate: instruction codes, no-beat type code,
// per-stream packet state.
package stream_chunk_gate_pkg;

  localparam logic [1:0] INSTR_IDLE  = 2'd0;
  localparam logic [1:0] INSTR_DROP  = 2'd1;
  localparam logic [1:0] INSTR_PASS  = 2'd2;
  localparam logic [1:0] INSTR_LIMIT = 2'd3;

  localparam logic [1:0] TYPE_NONE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_TRUNC = 2'd3
  } stream_state_e;

  function automatic logic is_beat(input logic [1:0] typ);
    return typ != TYPE_NONE;
  endfunction

endpackage

// File: rtl/stream_chunk_gate_if.sv
// Stream link: forward beat fields plus the backward instruction path travelling the other way.
// master drives beats and receives instructions; slave receives beats and drives instructions.
interface stream_chunk_gate_if #(
  parameter int unsigned DATA_WIDTH                  = 512,
  parameter int unsigned STREAM_ID_NUM               = 16,
  parameter int unsigned CHUNK_ID_NUM                = 32,
  parameter int unsigned CHANNEL_ID_NUM              = 1024,
  parameter int unsigned STATE_WIDTH                 = 32,
  parameter int unsigned INSTRUCTION_WIDTH           = 2,
  parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16
);
  localparam int unsigned SID_W   = $clog2(STREAM_ID_NUM);
  localparam int unsigned CHUNK_W = $clog2(CHUNK_ID_NUM);
  localparam int unsigned CID_W   = $clog2(CHANNEL_ID_NUM);

  logic [DATA_WIDTH-1:0]                  Data;
  logic [1:0]                             Type;
  logic                                   Last;
  logic [SID_W-1:0]                       StreamID;
  logic [CHUNK_W-1:0]                     ChunkID;
  logic [CID_W-1:0]                       ChannelID;
  logic [STATE_WIDTH-1:0]                 State;

  logic [INSTRUCTION_WIDTH-1:0]           InstructionType;
  logic [SID_W-1:0]                       InstructionStreamID;
  logic [CID_W-1:0]                       InstructionChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] InstructionParameter;

  modport master (
    output Data, Type, Last, StreamID, ChunkID, ChannelID, State,
    input  InstructionType, InstructionStreamID, InstructionChannelID, InstructionParameter
  );

  modport slave (
    input  Data, Type, Last, StreamID, ChunkID, ChannelID, State,
    output InstructionType, InstructionStreamID, InstructionChannelID, InstructionParameter
  );

endinterface

// File: rtl/stream_chunk_ctx.sv
// Per-stream context register file: enable bit, packet state and chunk counter,
// with a combinational indexed read and independent write ports.
module stream_chunk_ctx
  import stream_chunk_gate_pkg::*;
#(
  parameter int unsigned STREAM_ID_NUM = 16,
  parameter int unsigned CHUNK_ID_NUM  = 32,
  localparam int unsigned SID_W        = $clog2(STREAM_ID_NUM),
  localparam int unsigned CHUNK_W      = $clog2(CHUNK_ID_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SID_W-1:0]   rd_sid,
  output logic               rd_en_c,
  output stream_state_e      rd_st_c,
  output logic [CHUNK_W-1:0] rd_cnt_c,
  input  logic               ctx_wr,
  input  logic [SID_W-1:0]   ctx_wr_sid,
  input  stream_state_e      ctx_wr_st,
  input  logic [CHUNK_W-1:0] ctx_wr_cnt,
  input  logic               en_wr,
  input  logic [SID_W-1:0]   en_wr_sid,
  input  logic               en_wr_val
);

  logic [STREAM_ID_NUM-1:0] en_q;
  stream_state_e            st_q  [STREAM_ID_NUM];
  logic [CHUNK_W-1:0]       cnt_q [STREAM_ID_NUM];

  assign rd_en_c  = en_q[rd_sid];
  assign rd_st_c  = st_q[rd_sid];
  assign rd_cnt_c = cnt_q[rd_sid];

  // Packet state and counter, written back on every beat of the addressed stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STREAM_ID_NUM; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else if (ctx_wr) begin
      st_q[ctx_wr_sid]  <= ctx_wr_st;
      cnt_q[ctx_wr_sid] <= ctx_wr_cnt;
    end
  end

  // Enable bits, written by DROP/PASS instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '1;
    end else if (en_wr) begin
      en_q[en_wr_sid] <= en_wr_val;
    end
  end

endmodule

// File: rtl/stream_chunk_gate.sv
// Registered stream stage: rewrites ChunkID per stream, gates packets on DROP/PASS/LIMIT
// commands, forwards the instruction path upstream. Optional macro CHUNK_OVF_CHECK_EN.
module stream_chunk_gate
  import stream_chunk_gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                  = 512,
  parameter int unsigned STREAM_ID_NUM               = 16,
  parameter int unsigned CHUNK_ID_NUM                = 32,
  parameter int unsigned CHANNEL_ID_NUM              = 1024,
  parameter int unsigned STATE_WIDTH                 = 32,
  parameter int unsigned INSTRUCTION_WIDTH           = 2,
  parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  stream_chunk_gate_if.slave  up,
  stream_chunk_gate_if.master dn
`ifdef CHUNK_OVF_CHECK_EN
  ,
  output logic                err_ChunkOverflow
`endif
);

  localparam int unsigned SID_W   = $clog2(STREAM_ID_NUM);
  localparam int unsigned CHUNK_W = $clog2(CHUNK_ID_NUM);

  logic                rd_en_c;
  stream_state_e       rd_st_c;
  logic [CHUNK_W-1:0]  rd_cnt_c;
  logic [CHUNK_W:0]    limit_q;

  stream_state_e       cur_st_c;
  stream_state_e       nxt_st_c;
  logic [CHUNK_W-1:0]  nxt_cnt_c;
  logic                ctx_wr_c;
  logic                trunc_c;
  logic [1:0]          out_type_c;
  logic                out_last_c;
  logic                en_wr_c;
  logic                en_val_c;
`ifdef CHUNK_OVF_CHECK_EN
  localparam logic [CHUNK_W-1:0] CNT_MAX = CHUNK_W'(CHUNK_ID_NUM - 1);
  logic                ovf_set_c;
`endif

  stream_chunk_ctx #(
    .STREAM_ID_NUM (STREAM_ID_NUM),
    .CHUNK_ID_NUM  (CHUNK_ID_NUM)
  ) u_ctx (
    .clk        (clk),
    .rst        (rst),
    .rd_sid     (up.StreamID),
    .rd_en_c    (rd_en_c),
    .rd_st_c    (rd_st_c),
    .rd_cnt_c   (rd_cnt_c),
    .ctx_wr     (ctx_wr_c),
    .ctx_wr_sid (up.StreamID),
    .ctx_wr_st  (nxt_st_c),
    .ctx_wr_cnt (nxt_cnt_c),
    .en_wr      (en_wr_c),
    .en_wr_sid  (SID_W'(dn.InstructionStreamID)),
    .en_wr_val  (en_val_c)
  );

  assign en_wr_c  = (dn.InstructionType == INSTR_DROP) || (dn.InstructionType == INSTR_PASS);
  assign en_val_c = (dn.InstructionType == INSTR_PASS);

  // Per-stream packet FSM for the addressed stream; IDLE resolves to PASS/DROP on the first beat
  always_comb begin
    cur_st_c   = rd_st_c;
    nxt_st_c   = rd_st_c;
    nxt_cnt_c  = rd_cnt_c;
    ctx_wr_c   = 1'b0;
    out_type_c = TYPE_NONE;
    out_last_c = 1'b0;
`ifdef CHUNK_OVF_CHECK_EN
    ovf_set_c  = 1'b0;
`endif
    trunc_c    = (limit_q != '0) && ({1'b0, rd_cnt_c} >= (limit_q - (CHUNK_W+1)'(1)));

    if (rd_st_c == ST_IDLE) begin
      cur_st_c = rd_en_c ? ST_PASS : ST_DROP;
    end

    if (is_beat(up.Type)) begin
      ctx_wr_c = 1'b1;
      if (cur_st_c == ST_PASS) begin
        out_type_c = up.Type;
        out_last_c = up.Last;
        if (up.Last) begin
          nxt_st_c  = ST_IDLE;
          nxt_cnt_c = '0;
        end else if (trunc_c) begin
          out_last_c = 1'b1;
          nxt_st_c   = ST_TRUNC;
          nxt_cnt_c  = '0;
        end else begin
          nxt_st_c  = ST_PASS;
          nxt_cnt_c = rd_cnt_c + CHUNK_W'(1);
`ifdef CHUNK_OVF_CHECK_EN
          if (rd_cnt_c == CNT_MAX) begin
            nxt_cnt_c = rd_cnt_c;
            ovf_set_c = 1'b1;
          end
`endif
        end
      end else begin
        nxt_st_c = up.Last ? ST_IDLE : cur_st_c;
        if (up.Last) begin
          nxt_cnt_c = '0;
        end
      end
    end
  end

  // Forward beat, backward instruction and global limit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn.Data                 <= '0;
      dn.Type                 <= TYPE_NONE;
      dn.Last                 <= 1'b0;
      dn.StreamID             <= '0;
      dn.ChunkID              <= '0;
      dn.ChannelID            <= '0;
      dn.State                <= '0;
      up.InstructionType      <= '0;
      up.InstructionStreamID  <= '0;
      up.InstructionChannelID <= '0;
      up.InstructionParameter <= '0;
      limit_q                 <= '0;
    end else begin
      dn.Data                 <= up.Data;
      dn.Type                 <= out_type_c;
      dn.Last                 <= out_last_c;
      dn.StreamID             <= up.StreamID;
      dn.ChunkID              <= rd_cnt_c;
      dn.ChannelID            <= up.ChannelID;
      dn.State                <= up.State;
      up.InstructionType      <= dn.InstructionType;
      up.InstructionStreamID  <= dn.InstructionStreamID;
      up.InstructionChannelID <= dn.InstructionChannelID;
      up.InstructionParameter <= dn.InstructionParameter;
      if (dn.InstructionType == INSTR_LIMIT) begin
        limit_q <= dn.InstructionParameter[CHUNK_W:0];
      end
    end
  end

`ifdef CHUNK_OVF_CHECK_EN
  // Sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ChunkOverflow <= 1'b0;
    end else if (ovf_set_c) begin
      err_ChunkOverflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_chunk_gate.sv
// Scoreboard bench for stream_chunk_gate: directed packets push expected beats/instructions,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_stream_chunk_gate;
  import stream_chunk_gate_pkg::*;

  localparam int unsigned DW  = 512;
  localparam int unsigned SN  = 16;
  localparam int unsigned CN  = 32;
  localparam int unsigned CHN = 1024;
  localparam int unsigned STW = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_chunk_gate_if #(.DATA_WIDTH(DW), .STREAM_ID_NUM(SN), .CHUNK_ID_NUM(CN),
                         .CHANNEL_ID_NUM(CHN), .STATE_WIDTH(STW)) up_if ();
  stream_chunk_gate_if #(.DATA_WIDTH(DW), .STREAM_ID_NUM(SN), .CHUNK_ID_NUM(CN),
                         .CHANNEL_ID_NUM(CHN), .STATE_WIDTH(STW)) dn_if ();
`ifdef CHUNK_OVF_CHECK_EN
  logic err;
`endif

  stream_chunk_gate #(
    .DATA_WIDTH(DW), .STREAM_ID_NUM(SN), .CHUNK_ID_NUM(CN),
    .CHANNEL_ID_NUM(CHN), .STATE_WIDTH(STW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .up  (up_if.slave),
    .dn  (dn_if.master)
`ifdef CHUNK_OVF_CHECK_EN
    ,
    .err_ChunkOverflow (err)
`endif
  );

  typedef struct {
    int           due;
    logic [1:0]   typ;
    logic         last;
    logic [3:0]   sid;
    logic [4:0]   chunk;
    logic [9:0]   cid;
    logic [31:0]  st;
    logic [511:0] data;
  } beat_t;

  typedef struct {
    int          due;
    logic [1:0]  typ;
    logic [3:0]  sid;
    logic [9:0]  cid;
    logic [15:0] par;
  } instr_t;

  beat_t  bq[$];
  instr_t iq[$];
  beat_t  mb;
  instr_t mi;
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle_inputs();
    up_if.Type                 = TYPE_NONE;
    up_if.Last                 = 1'b0;
    dn_if.InstructionType      = INSTR_IDLE;
    dn_if.InstructionStreamID  = '0;
    dn_if.InstructionChannelID = '0;
    dn_if.InstructionParameter = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle_inputs();
  endtask

  // Drive one beat this cycle; push an expectation when it should reach downstream
  task automatic beat(input logic [3:0] sid, input logic last, input logic fwd,
                      input logic [4:0] chunk, input logic exp_last);
    beat_t b;
    up_if.Type      = 2'($urandom_range(1, 3));
    up_if.Last      = last;
    up_if.StreamID  = sid;
    up_if.ChunkID   = 5'($urandom);
    up_if.ChannelID = 10'($urandom);
    up_if.State     = 32'($urandom);
    for (int i = 0; i < 16; i++) up_if.Data[i*32 +: 32] = 32'($urandom);
    if (fwd) begin
      b.due   = cyc + 1;
      b.typ   = up_if.Type;
      b.last  = exp_last;
      b.sid   = sid;
      b.chunk = chunk;
      b.cid   = up_if.ChannelID;
      b.st    = up_if.State;
      b.data  = up_if.Data;
      bq.push_back(b);
    end
  endtask

  task automatic instr(input logic [1:0] t, input logic [3:0] sid, input logic [9:0] cid,
                       input logic [15:0] par);
    instr_t x;
    dn_if.InstructionType      = t;
    dn_if.InstructionStreamID  = sid;
    dn_if.InstructionChannelID = cid;
    dn_if.InstructionParameter = par;
    x.due = cyc + 1;
    x.typ = t;
    x.sid = sid;
    x.cid = cid;
    x.par = par;
    iq.push_back(x);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or an instruction
  always @(negedge clk) begin
    if (!rst) begin
      if (dn_if.Type != TYPE_NONE) begin
        if (bq.size() == 0) begin
          chk("spurious_beat", 512'(dn_if.Type), 512'(TYPE_NONE));
        end else begin
          mb = bq.pop_front();
          chk("beat_latency", 512'(cyc), 512'(mb.due));
          chk("beat_type", 512'(dn_if.Type), 512'(mb.typ));
          chk("beat_last", 512'(dn_if.Last), 512'(mb.last));
          chk("beat_sid", 512'(dn_if.StreamID), 512'(mb.sid));
          chk("beat_chunk", 512'(dn_if.ChunkID), 512'(mb.chunk));
          chk("beat_cid", 512'(dn_if.ChannelID), 512'(mb.cid));
          chk("beat_state", 512'(dn_if.State), 512'(mb.st));
          chk("beat_data", dn_if.Data, mb.data);
        end
      end else begin
        chk("nobeat_last", 512'(dn_if.Last), 512'(0));
      end
      if (up_if.InstructionType != INSTR_IDLE) begin
        if (iq.size() == 0) begin
          chk("spurious_instr", 512'(up_if.InstructionType), 512'(INSTR_IDLE));
        end else begin
          mi = iq.pop_front();
          chk("instr_latency", 512'(cyc), 512'(mi.due));
          chk("instr_type", 512'(up_if.InstructionType), 512'(mi.typ));
          chk("instr_sid", 512'(up_if.InstructionStreamID), 512'(mi.sid));
          chk("instr_cid", 512'(up_if.InstructionChannelID), 512'(mi.cid));
          chk("instr_par", 512'(up_if.InstructionParameter), 512'(mi.par));
        end
      end
    end
  end

  initial begin
    logic [4:0] ch;
    idle_inputs();
    rst = 1'b1;
    // Activity during reset must not leak out nor load the limit
    up_if.Type = 2'd1; up_if.Last = 1'b1; up_if.Data = '1; up_if.StreamID = 4'd3;
    dn_if.InstructionType = INSTR_LIMIT; dn_if.InstructionParameter = 16'h0002;
    repeat (3) @(negedge clk);
    chk("rst_type", 512'(dn_if.Type), 512'(0));
    chk("rst_last", 512'(dn_if.Last), 512'(0));
    chk("rst_data", dn_if.Data, 512'(0));
    chk("rst_sid", 512'(dn_if.StreamID), 512'(0));
    chk("rst_chunk", 512'(dn_if.ChunkID), 512'(0));
    chk("rst_itype", 512'(up_if.InstructionType), 512'(0));
    chk("rst_ipar", 512'(up_if.InstructionParameter), 512'(0));
`ifdef CHUNK_OVF_CHECK_EN
    chk("rst_err", 512'(err), 512'(0));
`endif
    idle_inputs();
    rst = 1'b0;

    // 3-beat packet on stream 2, then a single-beat packet
    next(); beat(2, 0, 1, 0, 0);
    next(); beat(2, 0, 1, 1, 0);
    next(); beat(2, 1, 1, 2, 1);
    next(); beat(2, 1, 1, 0, 1);

    // DROP stream 5 during beat 1: current packet survives, next is dropped, stream 6 unaffected
    next(); beat(5, 0, 1, 0, 0);
    next(); beat(5, 0, 1, 1, 0); instr(INSTR_DROP, 5, 10'd3, 16'h0);
    next(); beat(5, 0, 1, 2, 0);
    next(); beat(5, 1, 1, 3, 1);
    next(); beat(5, 0, 0, 0, 0);
    next(); beat(6, 0, 1, 0, 0);
    next(); beat(5, 0, 0, 0, 0);
    next(); beat(6, 1, 1, 1, 1);
    next(); beat(5, 1, 0, 0, 0);

    // PASS on the same edge as the first beat: that packet still dropped
    next(); beat(5, 0, 0, 0, 0); instr(INSTR_PASS, 5, 10'd0, 16'h0);
    next(); beat(5, 1, 0, 0, 0);
    next(); beat(5, 0, 1, 0, 0);
    next(); beat(5, 1, 1, 1, 1);

    // LIMIT=2 on a 5-beat packet
    next(); instr(INSTR_LIMIT, 0, 10'd0, 16'd2);
    next(); beat(1, 0, 1, 0, 0);
    next(); beat(1, 0, 1, 1, 1);
    next(); beat(1, 0, 0, 0, 0);
    next(); beat(1, 0, 0, 0, 0);
    next(); beat(1, 1, 0, 0, 0);
    next(); beat(1, 0, 1, 0, 0);
    next(); beat(1, 1, 1, 1, 1);

    // Mid-packet LIMIT change: old limit on its own edge, truncation on the next beat
    next(); instr(INSTR_LIMIT, 0, 10'd0, 16'd0);
    next(); beat(4, 0, 1, 0, 0);
    next(); beat(4, 0, 1, 1, 0);
    next(); beat(4, 0, 1, 2, 0); instr(INSTR_LIMIT, 0, 10'd0, 16'd2);
    next(); beat(4, 0, 1, 3, 1);
    next(); beat(4, 1, 0, 0, 0);
    next(); instr(INSTR_LIMIT, 0, 10'd0, 16'd0);

    // Backward instruction pass-through, IDLE the cycle after
    next(); instr(INSTR_LIMIT, 7, 10'd100, 16'hBEEF);
    next();
    next();
    chk("instr_idle_after", 512'(up_if.InstructionType), 512'(INSTR_IDLE));
    instr(INSTR_LIMIT, 0, 10'd0, 16'd0);

    // 34-beat packet across the chunk counter range
    for (int i = 0; i < 34; i++) begin
      next();
`ifdef CHUNK_OVF_CHECK_EN
      ch = (i > 31) ? 5'd31 : 5'(i);
`else
      ch = 5'(i);
`endif
      beat(9, (i == 33), 1, ch, (i == 33));
    end
    next(); next();
`ifdef CHUNK_OVF_CHECK_EN
    chk("ovf_err_set", 512'(err), 512'(1));
`endif

    // Reset mid-packet: context discarded, next beat starts at ChunkID 0
    next(); beat(3, 0, 1, 0, 0);
    next(); beat(3, 0, 1, 1, 0);
    next();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_type", 512'(dn_if.Type), 512'(0));
    chk("async_rst_chunk", 512'(dn_if.ChunkID), 512'(0));
`ifdef CHUNK_OVF_CHECK_EN
    chk("async_rst_err", 512'(err), 512'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    next(); beat(3, 1, 1, 0, 1);

    next(); next(); next();
    chk("beat_queue_drained", 512'(bq.size()), 512'(0));
    chk("instr_queue_drained", 512'(iq.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
